// File: rtl/register_bank_wb_if.sv
// Decode/writeback-facing bus of the register bank: read ports, issue handshake,
// WB write port and the stall response.
interface register_bank_wb_if #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned ADDR_WIDTH = 3
) ();
    logic [ADDR_WIDTH-1:0] read_addr1;
    logic [ADDR_WIDTH-1:0] read_addr2;
    logic                  use1;
    logic                  use2;
    logic                  issue_valid;
    logic                  issue_wr;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    logic                  stall;

    modport master (
        output read_addr1, read_addr2, use1, use2,
        output issue_valid, issue_wr, issue_rd,
        output write_enable, write_addr, write_data,
        input  read_data1, read_data2, stall
    );

    modport slave (
        input  read_addr1, read_addr2, use1, use2,
        input  issue_valid, issue_wr, issue_rd,
        input  write_enable, write_addr, write_data,
        output read_data1, read_data2, stall
    );
endinterface

// File: rtl/register_bank_wb.sv
// Register bank with WB-to-read bypass and a per-register pending-write counter
// that stalls decode while a source operand is still in flight.
module register_bank_wb #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input logic              clock,
    input logic              reset,
    register_bank_wb_if.slave bus
);
    localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [DATA_WIDTH-1:0] regs_d [NumRegs];
    logic [1:0]            pend_q [NumRegs];
    logic [1:0]            pend_d [NumRegs];

    logic       wr_active;
    logic [1:0] pend_rs1;
    logic [1:0] pend_rs2;
    logic [1:0] pend_rd;
    logic [1:0] pend_wa;
    logic       hazard1;
    logic       hazard2;
    logic       dest_full;
    logic       stall_int;
    logic       inc;
    logic       dec;

    assign wr_active = bus.write_enable && (bus.write_addr != '0);
    assign pend_rs1  = pend_q[bus.read_addr1];
    assign pend_rs2  = pend_q[bus.read_addr2];
    assign pend_rd   = pend_q[bus.issue_rd];
    assign pend_wa   = pend_q[bus.write_addr];

    // Last outstanding write retiring this cycle is covered by the bypass.
    assign hazard1 = bus.use1 && (bus.read_addr1 != '0) && (pend_rs1 != 2'd0) &&
                     !((pend_rs1 == 2'd1) && wr_active && (bus.write_addr == bus.read_addr1));
    assign hazard2 = bus.use2 && (bus.read_addr2 != '0) && (pend_rs2 != 2'd0) &&
                     !((pend_rs2 == 2'd1) && wr_active && (bus.write_addr == bus.read_addr2));

    assign dest_full = bus.issue_wr && (bus.issue_rd != '0) && (pend_rd == 2'd3);
    assign stall_int = bus.issue_valid && (hazard1 || hazard2 || dest_full);

    assign inc = bus.issue_valid && bus.issue_wr && !stall_int && (bus.issue_rd != '0);
    assign dec = wr_active && (pend_wa != 2'd0);

    assign bus.stall = stall_int;

    always_comb begin
        for (int unsigned r = 0; r < NumRegs; r++) begin
            regs_d[r] = regs_q[r];
            if (wr_active && (bus.write_addr == ADDR_WIDTH'(r))) begin
                regs_d[r] = bus.write_data;
            end
            pend_d[r] = pend_q[r]
                      + {1'b0, inc && (bus.issue_rd == ADDR_WIDTH'(r))}
                      - {1'b0, dec && (bus.write_addr == ADDR_WIDTH'(r))};
        end
    end

    always_comb begin
        bus.read_data1 = '0;
        if (bus.read_addr1 != '0) begin
            if (wr_active && (bus.write_addr == bus.read_addr1)) begin
                bus.read_data1 = bus.write_data;
            end else begin
                bus.read_data1 = regs_q[bus.read_addr1];
            end
        end
    end

    always_comb begin
        bus.read_data2 = '0;
        if (bus.read_addr2 != '0) begin
            if (wr_active && (bus.write_addr == bus.read_addr2)) begin
                bus.read_data2 = bus.write_data;
            end else begin
                bus.read_data2 = regs_q[bus.read_addr2];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned r = 0; r < NumRegs; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= 2'd0;
            end
        end else begin
            for (int unsigned r = 0; r < NumRegs; r++) begin
                regs_q[r] <= regs_d[r];
                pend_q[r] <= pend_d[r];
            end
        end
    end
endmodule

// File: tb/tb_register_bank_wb.sv
// Directed scenarios plus randomized traffic checked against a counting
// reference model of the register bank and its write scoreboard.
module tb_register_bank_wb;
    localparam int unsigned DW = 20;
    localparam int unsigned AW = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [DW-1:0] mregs [8];
    int            mpend [8];

    register_bank_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    register_bank_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // A source is blocked while any write to it is in flight, unless the only
    // remaining one is the write retiring right now.
    function automatic bit src_blocked(input bit use_it, input int a);
        if (!use_it || a == 0 || mpend[a] == 0) return 1'b0;
        if (mpend[a] == 1 && bus.write_enable && int'(bus.write_addr) == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_stall();
        bit full;
        full = bus.issue_wr && bus.issue_rd != 0 && mpend[bus.issue_rd] == 3;
        return bus.issue_valid && (src_blocked(bus.use1, int'(bus.read_addr1)) ||
                                   src_blocked(bus.use2, int'(bus.read_addr2)) || full);
    endfunction

    function automatic logic [DW-1:0] model_read(input int a);
        if (a == 0) return '0;
        if (bus.write_enable && int'(bus.write_addr) == a) return bus.write_data;
        return mregs[a];
    endfunction

    function automatic void model_update();
        bit s;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mregs[i] = '0;
                mpend[i] = 0;
            end
            return;
        end
        s = model_stall();
        if (bus.write_enable && bus.write_addr != 0) begin
            mregs[bus.write_addr] = bus.write_data;
            if (mpend[bus.write_addr] > 0) mpend[bus.write_addr]--;
        end
        if (bus.issue_valid && bus.issue_wr && !s && bus.issue_rd != 0) mpend[bus.issue_rd]++;
    endfunction

    task automatic set_idle();
        bus.read_addr1   = '0;
        bus.read_addr2   = '0;
        bus.use1         = 1'b0;
        bus.use2         = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.issue_wr     = 1'b0;
        bus.issue_rd     = '0;
        bus.write_enable = 1'b0;
        bus.write_addr   = '0;
        bus.write_data   = '0;
    endtask

    task automatic sample_check(input string tag);
        @(negedge clock);
        check_eq({tag, "_rd1"}, 32'(bus.read_data1), 32'(model_read(int'(bus.read_addr1))));
        check_eq({tag, "_rd2"}, 32'(bus.read_data2), 32'(model_read(int'(bus.read_addr2))));
        check_eq({tag, "_stall"}, 32'(bus.stall), 32'(model_stall()));
    endtask

    task automatic advance();
        @(posedge clock);
        model_update();
        #1;
    endtask

    initial begin
        int q[$];
        set_idle();
        reset = 1'b1;
        advance();
        reset = 1'b0;

        // Reset contents
        for (int i = 1; i < 8; i++) begin
            bus.read_addr1 = AW'(i);
            bus.read_addr2 = AW'(8 - i);
            sample_check("reset_read");
            check_eq("reset_zero", 32'(bus.read_data1), 32'h0);
            check_eq("reset_nostall", 32'(bus.stall), 32'h0);
            advance();
        end

        // r0 ignores writes
        set_idle();
        bus.write_enable = 1'b1;
        bus.write_data   = 20'hABCDE;
        sample_check("r0_write");
        check_eq("r0_nobypass", 32'(bus.read_data1), 32'h0);
        advance();
        bus.write_enable = 1'b0;
        sample_check("r0_read");
        check_eq("r0_zero", 32'(bus.read_data1), 32'h0);
        advance();

        // Write with same-cycle bypass, then from storage
        bus.write_enable = 1'b1;
        bus.write_addr   = 3'd3;
        bus.write_data   = 20'h12345;
        bus.read_addr1   = 3'd3;
        sample_check("bypass");
        check_eq("bypass_val", 32'(bus.read_data1), 32'h12345);
        advance();
        bus.write_enable = 1'b0;
        sample_check("stored");
        check_eq("stored_val", 32'(bus.read_data1), 32'h12345);
        advance();

        // RAW stall on r5 through to its WB cycle
        set_idle();
        bus.issue_valid = 1'b1;
        bus.issue_wr    = 1'b1;
        bus.issue_rd    = 3'd5;
        sample_check("raw_issue");
        advance();
        bus.issue_wr   = 1'b0;
        bus.use2       = 1'b1;
        bus.read_addr2 = 3'd5;
        for (int i = 0; i < 2; i++) begin
            sample_check("raw_wait");
            check_eq("raw_stall", 32'(bus.stall), 32'h1);
            advance();
        end
        bus.write_enable = 1'b1;
        bus.write_addr   = 3'd5;
        bus.write_data   = 20'h0F0F0;
        sample_check("raw_wb");
        check_eq("raw_release", 32'(bus.stall), 32'h0);
        check_eq("raw_bypass", 32'(bus.read_data2), 32'h0F0F0);
        advance();

        // Unused operand does not stall
        set_idle();
        bus.issue_valid = 1'b1;
        bus.issue_wr    = 1'b1;
        bus.issue_rd    = 3'd6;
        sample_check("unused_issue");
        advance();
        bus.issue_wr   = 1'b0;
        bus.read_addr2 = 3'd6;
        sample_check("unused_read");
        check_eq("unused_nostall", 32'(bus.stall), 32'h0);
        advance();
        set_idle();
        bus.write_enable = 1'b1;
        bus.write_addr   = 3'd6;
        bus.write_data   = 20'h00001;
        sample_check("unused_wb");
        advance();

        // Counter limits on r2
        set_idle();
        bus.issue_valid = 1'b1;
        bus.issue_wr    = 1'b1;
        bus.issue_rd    = 3'd2;
        for (int i = 0; i < 3; i++) begin
            sample_check("cnt_fill");
            check_eq("cnt_fill_go", 32'(bus.stall), 32'h0);
            advance();
        end
        sample_check("cnt_full");
        check_eq("cnt_full_stall", 32'(bus.stall), 32'h1);
        advance();
        bus.issue_valid  = 1'b0;
        bus.write_enable = 1'b1;
        bus.write_addr   = 3'd2;
        bus.write_data   = 20'h00022;
        sample_check("cnt_wb");
        advance();
        bus.issue_valid = 1'b1;
        bus.write_data  = 20'h00033;
        sample_check("cnt_both");
        check_eq("cnt_both_go", 32'(bus.stall), 32'h0);
        advance();
        bus.write_enable = 1'b0;
        sample_check("cnt_refill");
        check_eq("cnt_refill_go", 32'(bus.stall), 32'h0);
        advance();
        sample_check("cnt_unchanged");
        check_eq("cnt_unchanged_stall", 32'(bus.stall), 32'h1);
        advance();
        bus.issue_valid  = 1'b0;
        bus.write_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_check("cnt_drain");
            advance();
        end

        // Mid-run reset discards data and pending state
        set_idle();
        bus.write_enable = 1'b1;
        bus.write_addr   = 3'd4;
        bus.write_data   = 20'h00077;
        sample_check("mid_seed");
        advance();
        bus.write_enable = 1'b0;
        bus.issue_valid  = 1'b1;
        bus.issue_wr     = 1'b1;
        bus.issue_rd     = 3'd4;
        for (int i = 0; i < 2; i++) begin
            sample_check("mid_issue");
            advance();
        end
        set_idle();
        reset = 1'b1;
        bus.read_addr1 = 3'd4;
        sample_check("mid_reset");
        advance();
        reset = 1'b0;
        bus.issue_valid = 1'b1;
        bus.use1        = 1'b1;
        sample_check("mid_after");
        check_eq("mid_r4_zero", 32'(bus.read_data1), 32'h0);
        check_eq("mid_nostall", 32'(bus.stall), 32'h0);
        advance();
        set_idle();
        bus.write_enable = 1'b1;
        bus.write_addr   = 3'd4;
        bus.write_data   = 20'h00055;
        sample_check("mid_spurious");
        advance();
        bus.write_enable = 1'b0;
        bus.issue_valid  = 1'b1;
        bus.use1         = 1'b1;
        bus.read_addr1   = 3'd4;
        sample_check("mid_post");
        check_eq("mid_post_stall", 32'(bus.stall), 32'h0);
        check_eq("mid_post_val", 32'(bus.read_data1), 32'h00055);
        advance();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            reset            = ($urandom_range(0, 99) == 0);
            bus.read_addr1   = AW'($urandom);
            bus.read_addr2   = AW'($urandom);
            bus.use1         = 1'($urandom);
            bus.use2         = 1'($urandom);
            bus.issue_valid  = ($urandom_range(0, 3) != 0);
            bus.issue_wr     = 1'($urandom);
            bus.issue_rd     = AW'($urandom);
            bus.write_enable = ($urandom_range(0, 9) < 4);
            bus.write_data   = DW'($urandom);
            q.delete();
            for (int i = 1; i < 8; i++) if (mpend[i] > 0) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 9) < 7)
                bus.write_addr = AW'(q[$urandom_range(0, q.size() - 1)]);
            else
                bus.write_addr = AW'($urandom);
            if (reset) begin
                advance();
            end else begin
                sample_check("rand");
                advance();
            end
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/register_bank_wb.md
# register_bank_wb

Writer-side counterpart of the ID/EX capture path. An 8 × 20-bit register bank that feeds the decode-stage read ports and accepts results from the writeback stage. Contains a per-register pending-write scoreboard that raises `stall` toward fetch/decode while a source operand still has an outstanding write. Sits between the decode stage (read/issue side) and the WB stage (write side) of the pipelined processor.

## Interface
- `DATA_WIDTH`, 20, register and data width
- `ADDR_WIDTH`, 3, register address width (2^ADDR_WIDTH registers)
- `clock`  in  1  single clock, all state updates on posedge
- `reset`  in  1  synchronous, active-high; sampled on posedge clock
- `read_addr1`  in  ADDR_WIDTH  source register 1 address from decode
- `read_addr2`  in  ADDR_WIDTH  source register 2 address from decode
- `use1`  in  1  decoded instruction actually reads source 1
- `use2`  in  1  decoded instruction actually reads source 2
- `issue_valid`  in  1  decode presents an instruction this cycle
- `issue_wr`  in  1  that instruction writes a destination
- `issue_rd`  in  ADDR_WIDTH  destination register of issuing instruction
- `write_enable`  in  1  WB stage retires a write this cycle
- `write_addr`  in  ADDR_WIDTH  WB destination register
- `write_data`  in  DATA_WIDTH  WB result
- `read_data1`  out  DATA_WIDTH  combinational source 1 value
- `read_data2`  out  DATA_WIDTH  combinational source 2 value
- `stall`  out  1  combinational; hold fetch/decode, inject bubble into ID/EX

## Operation
- Register 0 hardwired to zero: reads return 0, writes ignored, never pending, never causes stall.
- Read ports are combinational. Write-to-read bypass: if `write_enable` and `write_addr == read_addrN` (nonzero), `read_dataN = write_data`; otherwise the stored value.
- Write: on posedge, if `write_enable` and `write_addr != 0`, `regs[write_addr] <= write_data`.
- Scoreboard: 2-bit saturating-free counter `pend[r]` per register (max 3 writes in flight: EX, MEM, WB).
  - inc = `issue_valid && issue_wr && !stall && issue_rd != 0`
  - dec = `write_enable && write_addr != 0 && pend[write_addr] != 0`
  - Same register inc and dec in one cycle: counter unchanged.
  - dec with `pend == 0` (spurious WB): counter stays 0, data still written.
- Source hazard for port N: `useN && read_addrN != 0 && pend[read_addrN] != 0`, cleared when `pend == 1` and this cycle's WB retires that register (bypass supplies the value).
- `stall = issue_valid && (hazard1 || hazard2 || (issue_wr && issue_rd != 0 && pend[issue_rd] == 3))`.
- `stall` suppresses the increment for that cycle; decode re-presents the same instruction next cycle.

## Timing
- Reset (sync): all `regs` ← 0, all `pend` ← 0. Outputs after reset edge: `read_data1/2 = 0` (unless bypass active), `stall = 0` unless `issue_valid` with no hazard possible, so `stall = 0`.
- `reset` asserted mid-operation: overrides writes and increments in the same edge. Pending state is discarded.
- Write latency: a value written at edge k is readable from storage after edge k. It is readable via bypass during cycle k itself.
- Scoreboard update latency: one edge. An instruction issued at edge k makes `pend` nonzero from cycle k+1.
- Stall is a pure function of current inputs and `pend`, with no registered delay.
- Back-to-back dependent instructions (producer issued at edge k, 3-stage writeback) stall for cycles k+1..k+2 and proceed in the WB cycle via bypass.

## Test plan
- Reset then read: assert `reset` 1 cycle, read r1..r7 → all 0, `stall = 0`. Write r0 = 0xABCDE → read r0 = 0.
- Write/bypass: `write_enable = 1`, `write_addr = 3`, `write_data = 0x12345` with `read_addr1 = 3` the same cycle → `read_data1 = 0x12345`. Next cycle with no write → still 0x12345.
- RAW stall: issue writer to r5 (`issue_wr = 1`). Next cycle issue a reader with `read_addr2 = 5`, `use2 = 1` → `stall = 1` until the WB cycle for r5 (data 0x0F0F0). In that cycle `stall = 0` and `read_data2 = 0x0F0F0`.
- Unused operand: same as the RAW stall case but `use2 = 0` → `stall = 0`.
- Counter limits: issue 3 writes to r2 without WB → `pend[2] = 3`. A fourth issue to r2 → `stall = 1`. Simultaneous WB to r2 and issue to r2 (with `pend < 3`) → counter unchanged.
- Mid-run reset: with `pend[4] = 2` and r4 = 0x00077, assert `reset` → r4 reads 0. A reader of r4 → `stall = 0`. A spurious WB to r4 afterwards leaves `pend` at 0.
